// File: rtl/jtkicker_romrsp_if.sv
// Memory-side read bus of the kicker ROM responder: one outstanding word read,
// request held until acknowledged, data returned with a one-cycle ready pulse.
interface jtkicker_romrsp_if;
  logic [20:0] mem_addr;
  logic        mem_rd;
  logic        mem_ack;
  logic        mem_rdy;
  logic [15:0] mem_din;

  modport master (
    output mem_addr,
    output mem_rd,
    input  mem_ack,
    input  mem_rdy,
    input  mem_din
  );

  modport slave (
    input  mem_addr,
    input  mem_rd,
    output mem_ack,
    output mem_rdy,
    output mem_din
  );
endinterface

// File: rtl/jtkicker_romrsp.sv
// Four-slot ROM responder with a one-word cache per slot and a fixed-priority
// memory arbiter. Define JTKICKER_PCM_SLOT_EN to build slot 3 (PCM).
module jtkicker_romrsp #(
  parameter logic [21:0] SLOT1_OFFSET = 22'h00_0000,
  parameter logic [21:0] SLOT2_OFFSET = 22'h00_0000,
  parameter logic [21:0] SLOT3_OFFSET = 22'h00_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        slot0_cs,
  input  logic [21:0] slot0_addr,
  output logic        slot0_ok,
  output logic [7:0]  slot0_dout,
  input  logic        slot1_cs,
  input  logic [21:0] slot1_addr,
  output logic        slot1_ok,
  output logic [7:0]  slot1_dout,
  input  logic        slot2_cs,
  input  logic [21:0] slot2_addr,
  output logic        slot2_ok,
  output logic [7:0]  slot2_dout,
  input  logic        slot3_cs,
  input  logic [21:0] slot3_addr,
  output logic        slot3_ok,
  output logic [7:0]  slot3_dout,
  jtkicker_romrsp_if.master mem
);

`ifdef JTKICKER_PCM_SLOT_EN
  localparam int NS = 4;
`else
  localparam int NS = 3;
  logic unused_slot3;
  assign unused_slot3 = ^{slot3_cs, slot3_addr};
`endif

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2} state_t;

  state_t      st;
  logic [1:0]  gnt_id;
  logic [20:0] gnt_word;
  logic [1:0]  pick;
  logic [20:0] pick_word;
  logic        fill;
  logic [3:0]  cs_a;
  logic [21:0] addr_a [4];
  logic [3:0]  hit;
  logic [3:0]  miss;
  logic [3:0]  ok_a;
  logic [7:0]  dout_a [4];

  function automatic logic [20:0] slot_offset(input logic [1:0] id);
    case (id)
      2'd1:    slot_offset = SLOT1_OFFSET[20:0];
      2'd2:    slot_offset = SLOT2_OFFSET[20:0];
      2'd3:    slot_offset = SLOT3_OFFSET[20:0];
      default: slot_offset = 21'd0;
    endcase
  endfunction

  function automatic logic [7:0] pick_byte(input logic [15:0] word, input logic hi);
    pick_byte = hi ? word[15:8] : word[7:0];
  endfunction

  always_comb begin
    cs_a[0]   = slot0_cs;
    cs_a[1]   = slot1_cs;
    cs_a[2]   = slot2_cs;
    addr_a[0] = slot0_addr;
    addr_a[1] = slot1_addr;
    addr_a[2] = slot2_addr;
`ifdef JTKICKER_PCM_SLOT_EN
    cs_a[3]   = slot3_cs;
    addr_a[3] = slot3_addr;
`else
    cs_a[3]   = 1'b0;
    addr_a[3] = 22'd0;
`endif
  end

  assign miss = cs_a & ~hit;
  assign fill = ((st == REQ) && mem.mem_ack && mem.mem_rdy) ||
                ((st == WAIT) && mem.mem_rdy);

  // Per-slot cache: valid/ok/dout are control and reset; tag/data only load on fill
  for (genvar i = 0; i < 4; i++) begin : g_slot
    if (i < NS) begin : g_cache
      logic        vld;
      logic        ok_p1;
      logic [7:0]  dout_p1;
      logic [20:0] tag;
      logic [15:0] data;
      logic        fill_me;

      assign fill_me = fill && (gnt_id == 2'(i));
      assign hit[i]  = cs_a[i] && vld && (addr_a[i][21:1] == tag);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld     <= 1'b0;
          ok_p1   <= 1'b0;
          dout_p1 <= 8'h00;
        end else begin
          if (fill_me) vld <= 1'b1;
          ok_p1   <= hit[i];
          dout_p1 <= hit[i] ? pick_byte(data, addr_a[i][0]) : 8'h00;
        end
      end

      always_ff @(posedge clk) begin
        if (fill_me) begin
          tag  <= gnt_word;
          data <= mem.mem_din;
        end
      end

      assign ok_a[i]   = ok_p1;
      assign dout_a[i] = dout_p1;
    end else begin : g_off
      assign hit[i]    = 1'b0;
      assign ok_a[i]   = 1'b0;
      assign dout_a[i] = 8'h00;
    end
  end

  // Lowest index wins
  always_comb begin
    pick = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (miss[i]) pick = 2'(i);
    end
  end

  assign pick_word = addr_a[pick][21:1];

  // Arbiter FSM: IDLE grants, REQ holds mem_rd until ack, WAIT for ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st           <= IDLE;
      mem.mem_rd   <= 1'b0;
      mem.mem_addr <= 21'd0;
      gnt_id       <= 2'd0;
      gnt_word     <= 21'd0;
    end else begin
      case (st)
        IDLE: begin
          mem.mem_rd <= 1'b0;
          if (|miss) begin
            gnt_id       <= pick;
            gnt_word     <= pick_word;
            mem.mem_addr <= pick_word + slot_offset(pick);
            mem.mem_rd   <= 1'b1;
            st           <= REQ;
          end
        end
        REQ: begin
          if (mem.mem_ack) begin
            mem.mem_rd <= 1'b0;
            st         <= mem.mem_rdy ? IDLE : WAIT;
          end
        end
        WAIT: begin
          mem.mem_rd <= 1'b0;
          if (mem.mem_rdy) st <= IDLE;
        end
        default: begin
          mem.mem_rd <= 1'b0;
          st         <= IDLE;
        end
      endcase
    end
  end

  assign slot0_ok   = ok_a[0];
  assign slot1_ok   = ok_a[1];
  assign slot2_ok   = ok_a[2];
  assign slot3_ok   = ok_a[3];
  assign slot0_dout = dout_a[0];
  assign slot1_dout = dout_a[1];
  assign slot2_dout = dout_a[2];
  assign slot3_dout = dout_a[3];

endmodule
